// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, one-word-per-line instruction cache between fetch and mem_ctrl.
// Defining ICACHE_PERF_EN adds the hit_cnt_out / miss_cnt_out lookup counters.
module icache_fetch #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_pc_in,
  output logic        fetch_ready_out,
  input  logic        flush_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_data_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];

  logic [31:0]        r_pc;
  logic               r_flushed;
  logic               r_inst_valid;
  logic [31:0]        r_inst;
  logic [31:0]        r_inst_pc;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic               w_fetch_ready;

  logic [INDEX_W-1:0] w_idx;
  logic [INDEX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_io;
  logic               w_fill_io;
  logic               w_hit;
  logic               w_accept;
  logic               w_done;
  logic               w_fill_we;

  assign w_idx      = fetch_pc_in[INDEX_W+1:2];
  assign w_tag      = fetch_pc_in[ADDR_W-1:INDEX_W+2];
  assign w_io       = (fetch_pc_in[ADDR_W-1:ADDR_W-2] == 2'b11);
  assign w_fill_idx = r_pc[INDEX_W+1:2];
  assign w_fill_tag = r_pc[ADDR_W-1:INDEX_W+2];
  assign w_fill_io  = (r_pc[ADDR_W-1:ADDR_W-2] == 2'b11);

  // IO addresses never hit, so they always go to memory and never allocate.
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !w_io;
  assign w_accept   = (r_state == ST_IDLE) && fetch_valid_in && !flush_in;
  assign w_done     = (r_state == ST_MISS) && mem_done_in;
  assign w_fill_we  = rdy_in && w_done && !w_fill_io;

  assign fetch_ready_out = w_fetch_ready;
  assign inst_valid_out  = r_inst_valid;
  assign inst_out        = r_inst;
  assign inst_pc_out     = r_inst_pc;
  assign mem_req_out     = r_mem_req;
  assign mem_addr_out    = r_mem_addr;

  // State register, frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next_state;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_hit) begin
          w_next_state = ST_MISS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MISS: begin
        if (mem_done_in) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_MISS;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_fetch_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_fetch_ready = 1'b1;
      ST_MISS: w_fetch_ready = 1'b0;
      ST_RESP: w_fetch_ready = 1'b0;
      default: w_fetch_ready = 1'b0;
    endcase
  end

  // Request latch, memory request and response registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc         <= 32'd0;
      r_flushed    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'd0;
    end else if (rdy_in) begin
      r_inst_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_flushed <= 1'b0;
          if (w_accept) begin
            r_pc <= fetch_pc_in;
            if (w_hit) begin
              r_inst_valid <= 1'b1;
              r_inst       <= r_data[w_idx];
              r_inst_pc    <= fetch_pc_in;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= {fetch_pc_in[31:2], 2'b00};
            end
          end
        end
        ST_MISS: begin
          // The fill cannot be aborted; a flush only cancels the response pulse.
          if (flush_in) begin
            r_flushed <= 1'b1;
          end
          if (mem_done_in) begin
            r_mem_req <= 1'b0;
            r_inst    <= mem_data_in;
            r_inst_pc <= r_pc;
          end
        end
        ST_RESP: r_inst_valid <= !(flush_in || r_flushed);
        default: r_inst_valid <= 1'b0;
      endcase
    end
  end

  // Line valid bits; only reset clears them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (w_fill_we) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written on fill completion.
  always_ff @(posedge clk_in) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data_in;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Lookup counters, one increment per accepted request.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (rdy_in && w_accept) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_out  = r_hit_cnt;
  assign miss_cnt_out = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: cache model, memory responder and per-cycle response compare.
module tb_icache_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_ready_out;
  logic        flush_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_out;
  logic [31:0] miss_cnt_out;
`endif

  icache_fetch dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .fetch_valid_in  (fetch_valid_in),
    .fetch_pc_in     (fetch_pc_in),
    .fetch_ready_out (fetch_ready_out),
    .flush_in        (flush_in),
    .inst_valid_out  (inst_valid_out),
    .inst_out        (inst_out),
    .inst_pc_out     (inst_pc_out),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_done_in     (mem_done_in),
    .mem_data_in     (mem_data_in)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_out     (hit_cnt_out),
    .miss_cnt_out    (miss_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Cache model: 64 lines indexed by word address, tag from the significant address bits.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int          m_hits = 0;
  int          m_misses = 0;

  typedef struct {
    int          due;
    logic [31:0] inst;
    logic [31:0] pc;
  } resp_t;
  resp_t exp_q[$];

  logic [31:0] exp_addr = 32'd0;
  int          n_req = 0;
  int          n_resp = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_inst = 32'd0;
  logic [31:0] last_pc = 32'd0;
  logic [31:0] addr_at_done = 32'd0;
  bit          prev_req = 1'b0;
  bit          auto_mem = 1'b1;
  int          lat = 4;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd64);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return (pc % 32'h0004_0000) >> 8;
  endfunction

  function automatic bit io_of(input logic [31:0] pc);
    return ((pc >> 16) & 32'd3) == 32'd3;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return !io_of(pc) && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Memory responder: done pulse when the request has been visible for lat cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk_in);
      if (auto_mem) begin
        mem_done_in = 1'b0;
        if (mem_req_out && rdy_in) begin
          if (wait_cnt == lat) begin
            mem_done_in  = 1'b1;
            mem_data_in  = mem_word(mem_addr_out);
            addr_at_done = mem_addr_out;
            done_cyc     = cyc;
            n_done++;
            wait_cnt     = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Per-cycle compare of responses and the memory request against the model.
  initial forever begin
    @(negedge clk_in);
    if (rst_in) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL resp_missing: no pulse at cycle %0d for pc %h", exp_q[0].due, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      if (inst_valid_out) begin
        tests++;
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          fails++;
          $display("FAIL resp_unexpected: pulse at cycle %0d pc %h inst %h, none due", cyc, inst_pc_out, inst_out);
        end else begin
          if (inst_out !== exp_q[0].inst || inst_pc_out !== exp_q[0].pc) begin
            fails++;
            $display("FAIL resp_data: got inst %h pc %h expected inst %h pc %h",
                     inst_out, inst_pc_out, exp_q[0].inst, exp_q[0].pc);
          end
          void'(exp_q.pop_front());
        end
        n_resp++;
        last_inst = inst_out;
        last_pc = inst_pc_out;
        last_resp_cyc = cyc;
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        tests++; fails++;
        $display("FAIL resp_missing: no pulse at cycle %0d for pc %h", cyc, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      if (mem_req_out) begin
        if (!prev_req) n_req++;
        tests++;
        if (mem_addr_out !== exp_addr || inst_valid_out) begin
          fails++;
          $display("FAIL mem_req: addr %h expected %h, inst_valid %b expected 0", mem_addr_out, exp_addr, inst_valid_out);
        end
      end
    end
    prev_req = mem_req_out;
  end

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk_in);
      fetch_valid_in = 1'b0;
      flush_in = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] pc, output bit is_miss);
    int guard;
    guard = 0;
    @(negedge clk_in);
    while (!fetch_ready_out && guard < 50) begin
      fetch_valid_in = 1'b0;
      @(negedge clk_in);
      guard++;
    end
    if (!fetch_ready_out) begin
      tests++; fails++;
      $display("FAIL ready_timeout: fetch_ready_out stuck 0 for pc %h", pc);
    end
    fetch_valid_in = 1'b1;
    fetch_pc_in = pc;
    flush_in = 1'b0;
    acc_cyc = cyc;
    is_miss = !model_hit(pc);
    if (is_miss) begin
      m_misses++;
      exp_addr = {pc[31:2], 2'b00};
    end else begin
      m_hits++;
      exp_q.push_back('{due: cyc + 1, inst: m_data[idx_of(pc)], pc: pc});
    end
  endtask

  // Waits for the fill; a flush at accept+flush_at cancels the response if no later than RESP.
  task automatic finish_miss(input logic [31:0] pc, input int flush_at);
    int start;
    int old;
    int k;
    bit got;
    bit flushed;
    start = cyc; old = n_done; got = 1'b0; k = 0;
    while (k < 80 && (!got || (flush_at > 0 && cyc < start + flush_at))) begin
      @(negedge clk_in);
      k++;
      fetch_valid_in = 1'b0;
      flush_in = (flush_at > 0 && cyc == start + flush_at);
      if (!got && n_done != old) begin
        got = 1'b1;
        flushed = (flush_at > 0) && (start + flush_at <= done_cyc + 1);
        if (!io_of(pc)) begin
          m_valid[idx_of(pc)] = 1'b1;
          m_tag[idx_of(pc)] = tag_of(pc);
          m_data[idx_of(pc)] = mem_word({pc[31:2], 2'b00});
        end
        if (!flushed) exp_q.push_back('{due: done_cyc + 2, inst: mem_word({pc[31:2], 2'b00}), pc: pc});
      end
    end
    @(negedge clk_in);
    flush_in = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL fill_timeout: no mem done for pc %h", pc);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input int flush_at);
    bit m;
    issue(pc, m);
    if (m) begin
      finish_miss(pc, flush_at);
    end else begin
      @(negedge clk_in);
      fetch_valid_in = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int p0;
    bit m;
    rst_in = 1'b0; rdy_in = 1'b1; fetch_valid_in = 1'b0; fetch_pc_in = 32'd0;
    flush_in = 1'b0; mem_done_in = 1'b0; mem_data_in = 32'd0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;

    #2;
    check("rst_inst_valid", inst_valid_out, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_inst_pc", inst_pc_out, 32'd0);
    check("rst_mem_req", mem_req_out, 32'd0);
    check("rst_mem_addr", mem_addr_out, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1 check("rst_ready", fetch_ready_out, 32'd1);

    // Cold miss
    r0 = n_req; p0 = n_resp;
    fetch(32'h0000_0100, 0);
    drain(2);
    check("cold_req_count", n_req - r0, 32'd1);
    check("cold_resp_count", n_resp - p0, 32'd1);
    check("cold_addr_at_done", addr_at_done, 32'h0000_0100);
    check("cold_inst", last_inst, 32'h0010_0093);
    check("cold_pc", last_pc, 32'h0000_0100);

    // Hit after fill, then four back-to-back hits
    r0 = n_req; p0 = n_resp;
    fetch(32'h0000_0100, 0);
    drain(1);
    check("hit_latency", last_resp_cyc - acc_cyc, 32'd1);
    check("hit_inst", last_inst, 32'h0010_0093);
    for (int i = 0; i < 4; i++) issue(32'h0000_0100, m);
    drain(2);
    check("hit_req_count", n_req - r0, 32'd0);
    check("hit_resp_count", n_resp - p0, 32'd5);

    // Conflict at index 0: 0x200 evicts 0x100
    r0 = n_req;
    fetch(32'h0000_0200, 0);
    drain(1);
    check("conflict_fill_latency", last_resp_cyc - acc_cyc, 32'd7);
    fetch(32'h0000_0100, 0);
    drain(1);
    check("conflict_req_count", n_req - r0, 32'd2);

    // Flush two cycles into a miss, then refetch hits
    r0 = n_req; p0 = n_resp;
    fetch(32'h0000_0300, 2);
    drain(3);
    check("flush_miss_resp", n_resp - p0, 32'd0);
    fetch(32'h0000_0300, 0);
    drain(1);
    check("flush_refetch_req", n_req - r0, 32'd1);
    check("flush_refetch_resp", n_resp - p0, 32'd1);

    // Flush in RESP cycle, then flush at IDLE with a hitting pc
    r0 = n_req; p0 = n_resp;
    fetch(32'h0000_0340, 6);
    drain(3);
    check("flush_resp_resp", n_resp - p0, 32'd0);
    @(negedge clk_in);
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0000_0300; flush_in = 1'b1;
    drain(3);
    check("flush_idle_resp", n_resp - p0, 32'd0);
    fetch(32'h0000_0340, 0);
    drain(1);
    check("flush_resp_refetch_req", n_req - r0, 32'd1);
    check("flush_resp_refetch_inst", last_inst, 32'h1357_989F);

    // rdy_in low for three cycles mid-miss, done ignored while frozen
    auto_mem = 1'b0; r0 = n_req;
    issue(32'h0000_0400, m);
    @(negedge clk_in); fetch_valid_in = 1'b0;
    @(negedge clk_in);
    check("stall_req_before", mem_req_out, 32'd1);
    check("stall_addr_before", mem_addr_out, 32'h0000_0400);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      mem_done_in = (i == 0); mem_data_in = 32'hCAFE_F00D;
      check("stall_req_frozen", mem_req_out, 32'd1);
      check("stall_addr_frozen", mem_addr_out, 32'h0000_0400);
      check("stall_ready_frozen", fetch_ready_out, 32'd0);
    end
    @(negedge clk_in); rdy_in = 1'b1; mem_done_in = 1'b0;
    @(negedge clk_in);
    check("stall_done_ignored", mem_req_out, 32'd1);
    mem_done_in = 1'b1; mem_data_in = 32'h1234_5678;
    m_valid[idx_of(32'h400)] = 1'b1; m_tag[idx_of(32'h400)] = tag_of(32'h400);
    m_data[idx_of(32'h400)] = 32'h1234_5678;
    exp_q.push_back('{due: cyc + 2, inst: 32'h1234_5678, pc: 32'h0000_0400});
    @(negedge clk_in); mem_done_in = 1'b0;
    check("stall_req_drop", mem_req_out, 32'd0);
    drain(3);
    auto_mem = 1'b1;
    fetch(32'h0000_0400, 0);
    drain(1);
    check("stall_hit_inst", last_inst, 32'h1234_5678);
    check("stall_req_count", n_req - r0, 32'd1);

    // Reset in the middle of a miss
    auto_mem = 1'b0;
    issue(32'h0000_0500, m);
    @(negedge clk_in); fetch_valid_in = 1'b0;
    @(negedge clk_in);
    check("rstmiss_req_before", mem_req_out, 32'd1);
    rst_in = 1'b0;
    #1;
    check("rstmiss_req_async", mem_req_out, 32'd0);
    check("rstmiss_addr_async", mem_addr_out, 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    exp_q.delete();
    m_hits = 0; m_misses = 0;
    @(negedge clk_in);
    @(negedge clk_in); rst_in = 1'b1;
    #1 check("rstmiss_ready", fetch_ready_out, 32'd1);
    auto_mem = 1'b1;

    // IO region bypass
    r0 = n_req; p0 = n_resp;
    fetch(32'h0003_0000, 0);
    fetch(32'h0003_0000, 0);
    drain(2);
    check("io_req_count", n_req - r0, 32'd2);
    check("io_resp_count", n_resp - p0, 32'd2);
    check("io_inst", last_inst, 32'h1354_9BDF);
`ifdef ICACHE_PERF_EN
    check("perf_miss_cnt", miss_cnt_out, 32'd2);
    check("perf_hit_cnt", hit_cnt_out, 32'd0);
`endif

    // Lines invalid after reset: 0x400 was cached before
    r0 = n_req;
    fetch(32'h0000_0400, 0);
    drain(1);
    check("rst_lines_invalid", n_req - r0, 32'd1);
`ifdef ICACHE_PERF_EN
    check("perf_miss_model", miss_cnt_out, m_misses);
    check("perf_hit_model", hit_cnt_out, m_hits);
`endif

    drain(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, word-per-line instruction cache between the instruction fetch stage and mem_ctrl.
- Accepts one PC per transaction from fetch and returns the 32-bit instruction word.
- On a miss, issues a single word read to mem_ctrl over a req/done handshake; mem_ctrl handles the 4-byte serialisation on the byte-wide RAM bus.
- Sits inside cpu, beside mem_ctrl, ahead of decode.

Parameters:
- INDEX_W, 6, log2 of line count (64 lines of one 32-bit word each).
- ADDR_W, 18, significant physical address bits (128KB RAM plus IO at [17:16]==2'b11).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; low freezes all state and outputs.
- fetch_valid_in  input  1  fetch presents a PC.
- fetch_pc_in  input  32  byte address; bits [1:0] ignored.
- fetch_ready_out  output  1  cache can accept a PC this cycle.
- flush_in  input  1  discard the in-flight fetch (branch redirect).
- inst_valid_out  output  1  one-cycle pulse, instruction available.
- inst_out  output  32  instruction word.
- inst_pc_out  output  32  PC belonging to inst_out.
- mem_req_out  output  1  word read request to mem_ctrl; held until done.
- mem_addr_out  output  32  word-aligned read address.
- mem_done_in  input  1  mem_ctrl read complete (one-cycle pulse).
- mem_data_in  input  32  read data, valid with mem_done_in.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all valid bits cleared; state IDLE.
  - inst_valid_out=0, inst_out=0, inst_pc_out=0, mem_req_out=0, mem_addr_out=0.
  - fetch_ready_out=1 once reset deasserts.
- Address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[ADDR_W-1:INDEX_W+2]
  - bits above ADDR_W-1 ignored.
- Storage: per line, valid bit, tag and 32-bit data, all registered.
- States: IDLE, MISS, RESP.
- IDLE:
  - fetch_ready_out=1.
  - On fetch_valid_in && !flush_in, latch the PC.
  - Hit (valid && tag match): next cycle inst_valid_out=1 with cached data and PC. Hit latency is 1 cycle. State stays IDLE, so back-to-back hits run at one per cycle.
  - Miss: next state MISS.
- MISS:
  - fetch_ready_out=0.
  - mem_req_out=1, mem_addr_out={pc[31:2],2'b00}; both held stable until mem_done_in.
  - On mem_done_in: write data, tag and valid into the line, drop mem_req_out the same edge, go to RESP.
- RESP:
  - inst_valid_out=1 for one cycle with mem_data, then IDLE.
  - Miss latency = mem_ctrl latency + 2 cycles from request acceptance.
- IO-region addresses (pc[17:16]==2'b11) are always treated as misses and never allocate a line. Data is still returned.
- flush_in:
  - IDLE: the request this cycle is not accepted; any hit response due next cycle is suppressed.
  - MISS: the memory transaction is not abortable. The fill completes and the line is written, but the RESP pulse is suppressed.
  - RESP: suppresses inst_valid_out that cycle.
  - flush_in does not clear valid bits.
- rdy_in low: no state, storage or output register changes. mem_req_out holds its value, and mem_done_in is ignored that cycle (mem_ctrl is frozen too).
- Reset mid-miss: mem_req_out drops immediately; no line is written.
- inst_valid_out is never asserted while mem_req_out=1.
- Each accepted request produces exactly one response unless flushed.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, adds two outputs: hit_cnt_out [31:0] and miss_cnt_out [31:0].
  - Each counter increments once per accepted, unflushed lookup; IO accesses count as misses.
  - Both counters reset to 0 and wrap modulo 2^32.
  - Both are frozen while rdy_in is low.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, fetch pc=0x0000_0100, mem returns 0x0010_0093 after 4 cycles -> mem_addr_out=0x100 held until done; inst_valid_out pulse with inst_out=0x0010_0093, inst_pc_out=0x100; one mem request total.
- Hit after fill: refetch 0x100 -> inst_valid_out exactly 1 cycle after accept, mem_req_out stays 0; then 4 back-to-back hits -> 4 consecutive valid pulses.
- Conflict: fill 0x100, then fetch 0x200 (same index for INDEX_W=6 with differing tag at bit 8) -> miss, line replaced; refetch 0x100 -> miss again.
- Flush during miss: fetch 0x300, assert flush_in 2 cycles later -> no inst_valid_out; refetch 0x300 -> hit, no memory request.
- IO bypass: fetch 0x0003_0000 twice -> two memory requests, no line allocated; with ICACHE_PERF_EN, miss_cnt_out=2, hit_cnt_out=0.
- Stall/reset: drop rdy_in for 3 cycles mid-MISS -> mem_req_out and mem_addr_out unchanged and done ignored; assert rst_in low mid-MISS -> mem_req_out=0 asynchronously, all lines invalid after release.
